// File: rtl/udp_rx_filter.sv
// UDP receive filter: collects the Ethernet/IPv4/UDP header of each incoming
// frame, checks the destination fields, then replays the buffered header and
// cuts the rest of the frame through, or discards the whole frame.
module udp_rx_filter #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A35000102,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8010A,
  parameter logic [15:0] LOCAL_PORT = 16'h04D2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] pass_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

  localparam logic [5:0] LAST_HDR = 6'd41;

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [7:0]  r_hdr [0:41];
  logic        r_mac_ok;
  logic        r_bc_ok;
  logic        r_rest_ok;
  logic        r_ended;
  logic [7:0]  r_m_tdata;
  logic        r_m_tvalid;
  logic        r_m_tlast;
  logic [15:0] r_pass_cnt;
  logic [15:0] r_drop_cnt;

  logic        w_s_xfer;
  logic        w_m_xfer;
  logic        w_mac_hit;
  logic        w_bc_hit;
  logic        w_rest_hit;
  logic        w_mac_ok;
  logic        w_bc_ok;
  logic        w_rest_ok;
  logic        w_hdr_ok;
  logic [5:0]  w_idx_inc;

  assign w_idx_inc = r_idx + 6'd1;
  assign w_s_xfer  = s_axis_tvalid & s_axis_tready;
  assign w_m_xfer  = m_axis_tvalid & m_axis_tready;
  assign pass_cnt  = r_pass_cnt;
  assign drop_cnt  = r_drop_cnt;

  // Per-byte field match for the byte currently at header index r_idx
  always_comb begin
    w_mac_hit  = 1'b1;
    w_bc_hit   = 1'b1;
    w_rest_hit = 1'b1;
    case (r_idx)
      6'd0: begin w_mac_hit = (s_axis_tdata == LOCAL_MAC[47:40]); w_bc_hit = (s_axis_tdata == 8'hFF); end
      6'd1: begin w_mac_hit = (s_axis_tdata == LOCAL_MAC[39:32]); w_bc_hit = (s_axis_tdata == 8'hFF); end
      6'd2: begin w_mac_hit = (s_axis_tdata == LOCAL_MAC[31:24]); w_bc_hit = (s_axis_tdata == 8'hFF); end
      6'd3: begin w_mac_hit = (s_axis_tdata == LOCAL_MAC[23:16]); w_bc_hit = (s_axis_tdata == 8'hFF); end
      6'd4: begin w_mac_hit = (s_axis_tdata == LOCAL_MAC[15:8]);  w_bc_hit = (s_axis_tdata == 8'hFF); end
      6'd5: begin w_mac_hit = (s_axis_tdata == LOCAL_MAC[7:0]);   w_bc_hit = (s_axis_tdata == 8'hFF); end
      6'd12: w_rest_hit = (s_axis_tdata == 8'h08);
      6'd13: w_rest_hit = (s_axis_tdata == 8'h00);
      6'd14: w_rest_hit = (s_axis_tdata == 8'h45);
      6'd23: w_rest_hit = (s_axis_tdata == 8'h11);
      6'd30: w_rest_hit = (s_axis_tdata == LOCAL_IP[31:24]);
      6'd31: w_rest_hit = (s_axis_tdata == LOCAL_IP[23:16]);
      6'd32: w_rest_hit = (s_axis_tdata == LOCAL_IP[15:8]);
      6'd33: w_rest_hit = (s_axis_tdata == LOCAL_IP[7:0]);
      6'd36: w_rest_hit = (s_axis_tdata == LOCAL_PORT[15:8]);
      6'd37: w_rest_hit = (s_axis_tdata == LOCAL_PORT[7:0]);
      default: ;
    endcase
  end

  // Running accept flags; index 0 starts a fresh frame so prior flags are ignored
  always_comb begin
    w_mac_ok  = ((r_idx == 6'd0) | r_mac_ok)  & w_mac_hit;
    w_bc_ok   = ((r_idx == 6'd0) | r_bc_ok)   & w_bc_hit;
    w_rest_ok = ((r_idx == 6'd0) | r_rest_ok) & w_rest_hit;
    w_hdr_ok  = (w_mac_ok | w_bc_ok) & w_rest_ok;
  end

  // Output steering: cut-through in PASS, registered replay/idle otherwise
  always_comb begin
    m_axis_tdata  = r_m_tdata;
    m_axis_tvalid = r_m_tvalid;
    m_axis_tlast  = r_m_tlast;
    s_axis_tready = 1'b1;
    case (r_state)
      REPLAY: s_axis_tready = 1'b0;
      PASS: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
      end
      default: s_axis_tready = 1'b1;
    endcase
  end

  // Header capture buffer (no reset needed; always written before being read)
  always_ff @(posedge clk) begin
    if (r_state == HDR && w_s_xfer) r_hdr[r_idx] <= s_axis_tdata;
  end

  // Frame FSM, replay output registers and frame counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HDR;
      r_idx      <= '0;
      r_mac_ok   <= 1'b0;
      r_bc_ok    <= 1'b0;
      r_rest_ok  <= 1'b0;
      r_ended    <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        HDR: if (w_s_xfer) begin
          r_mac_ok  <= w_mac_ok;
          r_bc_ok   <= w_bc_ok;
          r_rest_ok <= w_rest_ok;
          if (r_idx == LAST_HDR) begin
            r_idx <= '0;
            if (w_hdr_ok) begin
              // Byte 0 was captured long ago, so replay can start next cycle
              r_state    <= REPLAY;
              r_ended    <= s_axis_tlast;
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= r_hdr[0];
              r_m_tlast  <= 1'b0;
            end else if (s_axis_tlast) begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
              r_state <= DROP;
            end
          end else if (s_axis_tlast) begin
            r_idx      <= '0;
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end else begin
            r_idx <= w_idx_inc;
          end
        end
        REPLAY: if (w_m_xfer) begin
          if (r_idx == LAST_HDR) begin
            r_idx      <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            if (r_ended) begin
              r_state    <= HDR;
              r_pass_cnt <= r_pass_cnt + 16'd1;
            end else begin
              r_state <= PASS;
            end
          end else begin
            r_idx     <= w_idx_inc;
            r_m_tdata <= r_hdr[w_idx_inc];
            r_m_tlast <= r_ended & (w_idx_inc == LAST_HDR);
          end
        end
        PASS: if (w_s_xfer && s_axis_tlast) begin
          r_state    <= HDR;
          r_pass_cnt <= r_pass_cnt + 16'd1;
        end
        DROP: if (w_s_xfer && s_axis_tlast) begin
          r_state    <= HDR;
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
        default: r_state <= HDR;
      endcase
    end
  end

endmodule
